prog_rate_counter: RTL and testbench

//  Second-generation rate-divided display counter: a programmable tick divider drives a

---
 rtl/prc_pkg.sv | 29 ++
 rtl/prc_rate_divider.sv | 79 +++++++
 rtl/prog_rate_counter.sv | 115 +++++++++++
 tb/tb_prog_rate_counter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prc_pkg.sv
// prc_pkg
// Shared definitions for the programmable rate counter: the speed selector
// encoding and the divider period for each speed setting.
//   speed_e     : SPD_FAST (every clock), SPD_1HZ, SPD_HALF_HZ, SPD_QUARTER_HZ
//   prc_period  : returns the divider period in clocks for a speed and a
//                 clock frequency; only ever called with constant arguments
//                 so it folds away at elaboration.
package prc_pkg;

  typedef enum logic [1:0] {
    SPD_FAST       = 2'b00,
    SPD_1HZ        = 2'b01,
    SPD_HALF_HZ    = 2'b10,
    SPD_QUARTER_HZ = 2'b11
  } speed_e;

  // Period in input clocks between two divider ticks for a speed setting.
  function automatic int prc_period(input speed_e speed, input int freq);
    int period;
    case (speed)
      SPD_FAST:    period = 1;
      SPD_1HZ:     period = freq;
      SPD_HALF_HZ: period = 2 * freq;
      default:     period = 4 * freq;
    endcase
    return period;
  endfunction

endpackage

// File: rtl/prc_rate_divider.sv
// prc_rate_divider
// Programmable down-counting tick divider. Emits a one-clock Tick every
// period N of the selected speed while Run is high.
// Ports:
//   ClockIn      in  1  clock, all state on posedge
//   Reset        in  1  synchronous, active-high
//   Run          in  1  1 = divider advances, 0 = DivCount held
//   Load         in  1  restarts the period at the current speed
//   Speed        in  2  speed selector (prc_pkg::speed_e encoding)
//   SpeedChange  out 1  Speed differs from the registered speed this cycle
//   Tick         out 1  registered one-clock pulse at terminal count
module prc_rate_divider
  import prc_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Load,
  input  logic [1:0] Speed,
  output logic       SpeedChange,
  output logic       Tick
);

  localparam int DIV_W = $clog2(4 * CLOCK_FREQUENCY) + 1;

  localparam logic [DIV_W-1:0] RELOAD_FAST    = DIV_W'(prc_period(SPD_FAST, CLOCK_FREQUENCY) - 1);
  localparam logic [DIV_W-1:0] RELOAD_1HZ     = DIV_W'(prc_period(SPD_1HZ, CLOCK_FREQUENCY) - 1);
  localparam logic [DIV_W-1:0] RELOAD_HALF    = DIV_W'(prc_period(SPD_HALF_HZ, CLOCK_FREQUENCY) - 1);
  localparam logic [DIV_W-1:0] RELOAD_QUARTER = DIV_W'(prc_period(SPD_QUARTER_HZ, CLOCK_FREQUENCY) - 1);

  logic [DIV_W-1:0] DivCount;
  speed_e           SpeedQ;
  speed_e           speedNow;
  logic [DIV_W-1:0] reloadNow;
  logic [DIV_W-1:0] reloadHeld;

  // Reload value is a pure mux of elaboration-time constants; no runtime divide.
  function automatic logic [DIV_W-1:0] reloadFor(input speed_e speed);
    logic [DIV_W-1:0] value;
    case (speed)
      SPD_FAST:    value = RELOAD_FAST;
      SPD_1HZ:     value = RELOAD_1HZ;
      SPD_HALF_HZ: value = RELOAD_HALF;
      default:     value = RELOAD_QUARTER;
    endcase
    return value;
  endfunction

  assign speedNow    = speed_e'(Speed);
  assign reloadNow   = reloadFor(speedNow);
  assign reloadHeld  = reloadFor(SpeedQ);
  assign SpeedChange = (speedNow != SpeedQ);

  // Divider state. Load and a speed change both restart the period from the
  // top at the newly requested speed; Run low freezes DivCount in place so the
  // period resumes exactly where it paused.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      DivCount <= reloadNow;
      SpeedQ   <= speedNow;
      Tick     <= 1'b0;
    end else if (Load || SpeedChange) begin
      DivCount <= reloadNow;
      SpeedQ   <= speedNow;
      Tick     <= 1'b0;
    end else if (!Run) begin
      Tick <= 1'b0;
    end else if (DivCount == '0) begin
      DivCount <= reloadHeld;
      Tick     <= 1'b1;
    end else begin
      DivCount <= DivCount - DIV_W'(1);
      Tick     <= 1'b0;
    end
  end

endmodule

// File: rtl/prog_rate_counter.sv
// prog_rate_counter
// Rate-divided modulo up/down display counter with run/pause and synchronous
// load. The counter steps one clock after each divider Tick.
// Optional build macro: PRC_ONE_SHOT_EN -- counter stops at its terminal value
// (MODULUS-1 counting up, 0 counting down) and Wrap marks the arrival instead
// of a wrap-around. Without the macro the counter wraps freely.
// Ports:
//   ClockIn       in  1      clock, all state on posedge
//   Reset         in  1      synchronous, active-high
//   Speed         in  2      00 every clock, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz
//   Run           in  1      1 = divider and counter advance, 0 = hold
//   Up            in  1      1 = count up, 0 = count down
//   Load          in  1      synchronous load strobe
//   LoadValue     in  WIDTH  load value, clamped to MODULUS-1
//   CounterValue  out WIDTH  current count
//   Tick          out 1      one-clock divider terminal-count pulse
//   Wrap          out 1      one-clock pulse with a wrapping (or arriving) step
module prog_rate_counter
  import prc_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int WIDTH           = 4,
  parameter int MODULUS         = 16
) (
  input  logic             ClockIn,
  input  logic             Reset,
  input  logic [1:0]       Speed,
  input  logic             Run,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] CounterValue,
  output logic             Tick,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] TOP_VALUE = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic             speedChange;
  logic [WIDTH-1:0] loadClamped;
  logic [WIDTH-1:0] stepValue;
  logic             stepWrap;
  logic             stepNow;

  prc_rate_divider #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
  ) divider (
    .ClockIn    (ClockIn),
    .Reset      (Reset),
    .Run        (Run),
    .Load       (Load),
    .Speed      (Speed),
    .SpeedChange(speedChange),
    .Tick       (Tick)
  );

  assign loadClamped = (LoadValue > TOP_VALUE) ? TOP_VALUE : LoadValue;

  // A Tick already registered still produces its step on a speed-change
  // cycle even with Run low; otherwise Run low holds the count.
  assign stepNow = Tick && (speedChange || Run);

  // Next count and Wrap flag for one step in the current Up direction.
  always_comb begin
    stepValue = CounterValue;
    stepWrap  = 1'b0;
`ifdef PRC_ONE_SHOT_EN
    if (Up) begin
      if (CounterValue != TOP_VALUE) begin
        stepValue = CounterValue + ONE;
        stepWrap  = (CounterValue == TOP_VALUE - ONE);
      end
    end else begin
      if (CounterValue != '0) begin
        stepValue = CounterValue - ONE;
        stepWrap  = (CounterValue == ONE);
      end
    end
`else
    if (Up) begin
      if (CounterValue == TOP_VALUE) begin
        stepValue = '0;
        stepWrap  = 1'b1;
      end else begin
        stepValue = CounterValue + ONE;
      end
    end else begin
      if (CounterValue == '0) begin
        stepValue = TOP_VALUE;
        stepWrap  = 1'b1;
      end else begin
        stepValue = CounterValue - ONE;
      end
    end
`endif
  end

  // Count register. Load wins over any pending step and discards it.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      CounterValue <= '0;
      Wrap         <= 1'b0;
    end else if (Load) begin
      CounterValue <= loadClamped;
      Wrap         <= 1'b0;
    end else if (stepNow) begin
      CounterValue <= stepValue;
      Wrap         <= stepWrap;
    end else begin
      Wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_rate_counter.sv
// tb_prog_rate_counter
// Self-checking bench for prog_rate_counter (CLOCK_FREQUENCY=4, WIDTH=4,
// MODULUS=10). A cycle-level behavioural model tracks elapsed clocks since
// the last period restart and the count as plain integers; a compare process
// checks the DUT against it every cycle, and directed sequences pin the model
// with hand-worked literal values. Honours PRC_ONE_SHOT_EN like the design.
module tb_prog_rate_counter;

  localparam int FREQ = 4;
  localparam int W    = 4;
  localparam int MOD  = 10;

  logic         ClockIn = 1'b0;
  logic         Reset   = 1'b1;
  logic [1:0]   Speed   = 2'b01;
  logic         Run     = 1'b1;
  logic         Up      = 1'b1;
  logic         Load    = 1'b0;
  logic [W-1:0] LoadValue = '0;
  logic [W-1:0] CounterValue;
  logic         Tick;
  logic         Wrap;

  int tests    = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  typedef struct packed {
    int since;
    int speedQ;
    int count;
    bit tick;
    bit wrap;
  } model_t;

  model_t m = '0;

  logic       rndReset;
  logic       rndLoad;
  logic [3:0] rndValue;
  logic [1:0] rndSpeed;
  logic       rndRun;
  logic       rndUp;
  int         heldCount;

  prog_rate_counter #(
    .CLOCK_FREQUENCY(FREQ),
    .WIDTH          (W),
    .MODULUS        (MOD)
  ) dut (
    .ClockIn     (ClockIn),
    .Reset       (Reset),
    .Speed       (Speed),
    .Run         (Run),
    .Up          (Up),
    .Load        (Load),
    .LoadValue   (LoadValue),
    .CounterValue(CounterValue),
    .Tick        (Tick),
    .Wrap        (Wrap)
  );

  always #5 ClockIn = ~ClockIn;

  function automatic int tbPeriod(input int spd);
    case (spd)
      0:       return 1;
      1:       return FREQ;
      2:       return 2 * FREQ;
      default: return 4 * FREQ;
    endcase
  endfunction

  // One counter step from count c in the given direction.
  function automatic void modelStep(input int c, input bit up, output int nc, output bit w);
`ifdef PRC_ONE_SHOT_EN
    if (up) begin
      nc = (c == MOD - 1) ? c : c + 1;
      w  = (c != MOD - 1) && (nc == MOD - 1);
    end else begin
      nc = (c == 0) ? 0 : c - 1;
      w  = (c != 0) && (nc == 0);
    end
`else
    if (up) begin
      nc = (c + 1) % MOD;
      w  = (c == MOD - 1);
    end else begin
      nc = (c + MOD - 1) % MOD;
      w  = (c == 0);
    end
`endif
  endfunction

  // Next model state after one clock edge with the given inputs.
  function automatic model_t modelNext(input model_t s, input bit rst, input bit ld,
                                       input int lv, input int spd, input bit run, input bit up);
    model_t n;
    int     nc;
    bit     w;
    n      = s;
    n.tick = 1'b0;
    n.wrap = 1'b0;
    if (rst) begin
      n.since  = 0;
      n.speedQ = spd;
      n.count  = 0;
    end else if (ld) begin
      n.count  = (lv >= MOD) ? MOD - 1 : lv;
      n.since  = 0;
      n.speedQ = spd;
    end else if (spd != s.speedQ) begin
      n.since  = 0;
      n.speedQ = spd;
      if (s.tick) begin
        modelStep(s.count, up, nc, w);
        n.count = nc;
        n.wrap  = w;
      end
    end else if (run) begin
      n.since = s.since + 1;
      if (n.since == tbPeriod(s.speedQ)) begin
        n.tick  = 1'b1;
        n.since = 0;
      end
      if (s.tick) begin
        modelStep(s.count, up, nc, w);
        n.count = nc;
        n.wrap  = w;
      end
    end
    return n;
  endfunction

  // Model advances on the same edge as the DUT using the inputs it sees.
  always @(posedge ClockIn) begin
    m <= modelNext(m, Reset, Load, int'(LoadValue), int'(Speed), Run, Up);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge ClockIn) begin
    if (checkEn) begin
      checkOutput("model_count", int'(CounterValue), m.count);
      checkOutput("model_tick", int'(Tick), int'(m.tick));
      checkOutput("model_wrap", int'(Wrap), int'(m.wrap));
    end
  end

  task automatic applyStimulus(input logic rst, input logic ld, input logic [3:0] lv,
                               input logic [1:0] spd, input logic run, input logic up);
    @(negedge ClockIn);
    Reset     = rst;
    Load      = ld;
    LoadValue = lv;
    Speed     = spd;
    Run       = run;
    Up        = up;
  endtask

  task automatic waitEdge();
    @(posedge ClockIn);
    #1;
  endtask

  initial begin
    // Reset state
    applyStimulus(1, 0, 0, 2'b01, 1, 1);
    waitEdge();
    checkEn = 1'b1;
    waitEdge();
    checkOutput("reset_count", int'(CounterValue), 0);
    checkOutput("reset_tick", int'(Tick), 0);
    checkOutput("reset_wrap", int'(Wrap), 0);

    // 1 Hz from reset: Tick at edges 4, 8, 12; count steps one edge later
    applyStimulus(0, 0, 0, 2'b01, 1, 1);
    for (int e = 1; e <= 13; e++) begin
      waitEdge();
      checkOutput($sformatf("t1_tick_e%0d", e), int'(Tick), (e % 4 == 0) ? 1 : 0);
      checkOutput($sformatf("t1_count_e%0d", e), int'(CounterValue), (e - 1) / 4);
    end

`ifndef PRC_ONE_SHOT_EN
    // Every-clock speed from 8: 9, 0 with Wrap, 1; then down: 0, 9 with Wrap
    applyStimulus(0, 1, 4'd8, 2'b01, 1, 1);
    waitEdge();
    checkOutput("t2_load8", int'(CounterValue), 8);
    applyStimulus(0, 0, 0, 2'b00, 1, 1);
    waitEdge();
    checkOutput("t2_change_tick", int'(Tick), 0);
    waitEdge();
    checkOutput("t2_first_tick", int'(Tick), 1);
    checkOutput("t2_hold8", int'(CounterValue), 8);
    waitEdge();
    checkOutput("t2_count9", int'(CounterValue), 9);
    checkOutput("t2_nowrap9", int'(Wrap), 0);
    waitEdge();
    checkOutput("t2_count0", int'(CounterValue), 0);
    checkOutput("t2_wrap0", int'(Wrap), 1);
    waitEdge();
    checkOutput("t2_count1", int'(CounterValue), 1);
    checkOutput("t2_nowrap1", int'(Wrap), 0);
    applyStimulus(0, 0, 0, 2'b00, 1, 0);
    waitEdge();
    checkOutput("t2_down0", int'(CounterValue), 0);
    checkOutput("t2_down_nowrap", int'(Wrap), 0);
    waitEdge();
    checkOutput("t2_down9", int'(CounterValue), 9);
    checkOutput("t2_down_wrap", int'(Wrap), 1);
`endif

    // Speed 01 -> 11 mid-period: Tick low until 16 edges after the change
    applyStimulus(0, 0, 0, 2'b01, 1, 1);
    waitEdge();
    waitEdge();
    applyStimulus(0, 0, 0, 2'b11, 1, 1);
    for (int k = 0; k <= 32; k++) begin
      waitEdge();
      checkOutput($sformatf("t3_tick_k%0d", k), int'(Tick), (k > 0 && k % 16 == 0) ? 1 : 0);
    end

    // Pause with two decrements left in the period, then resume
    applyStimulus(0, 0, 0, 2'b01, 1, 1);
    waitEdge();
    waitEdge();
    heldCount = m.count;
    applyStimulus(0, 0, 0, 2'b01, 0, 1);
    for (int k = 1; k <= 7; k++) begin
      waitEdge();
      checkOutput($sformatf("t4_pause_tick%0d", k), int'(Tick), 0);
      checkOutput($sformatf("t4_pause_count%0d", k), int'(CounterValue), heldCount);
    end
    applyStimulus(0, 0, 0, 2'b01, 1, 1);
    for (int r = 1; r <= 3; r++) begin
      waitEdge();
      checkOutput($sformatf("t4_resume_tick%0d", r), int'(Tick), (r == 3) ? 1 : 0);
    end

    // Load clamp, then Reset overriding Load
    applyStimulus(0, 1, 4'd13, 2'b01, 1, 1);
    waitEdge();
    checkOutput("t5_clamp", int'(CounterValue), 9);
    applyStimulus(1, 1, 4'd5, 2'b01, 1, 1);
    waitEdge();
    checkOutput("t5_reset_over_load", int'(CounterValue), 0);

`ifdef PRC_ONE_SHOT_EN
    // One-shot: up from 7 stops at 9 with a single done pulse
    applyStimulus(0, 1, 4'd7, 2'b00, 1, 1);
    waitEdge();
    checkOutput("t6_load7", int'(CounterValue), 7);
    applyStimulus(0, 0, 0, 2'b00, 1, 1);
    waitEdge();
    checkOutput("t6_hold7", int'(CounterValue), 7);
    waitEdge();
    checkOutput("t6_count8", int'(CounterValue), 8);
    checkOutput("t6_nodone8", int'(Wrap), 0);
    waitEdge();
    checkOutput("t6_count9", int'(CounterValue), 9);
    checkOutput("t6_done", int'(Wrap), 1);
    for (int k = 0; k < 3; k++) begin
      waitEdge();
      checkOutput($sformatf("t6_stay9_%0d", k), int'(CounterValue), 9);
      checkOutput($sformatf("t6_nodone_%0d", k), int'(Wrap), 0);
    end
    applyStimulus(0, 0, 0, 2'b00, 1, 0);
    waitEdge();
    checkOutput("t6_reverse8", int'(CounterValue), 8);
`endif

    // Randomised traffic checked against the model every cycle
    rndSpeed = 2'b00;
    rndUp    = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rndReset = ($urandom_range(127) == 0);
      rndLoad  = ($urandom_range(19) == 0);
      rndValue = 4'($urandom_range(15));
      if ($urandom_range(31) == 0) rndSpeed = 2'($urandom_range(3));
      rndRun   = ($urandom_range(7) != 0);
      if ($urandom_range(7) == 0) rndUp = ~rndUp;
      applyStimulus(rndReset, rndLoad, rndValue, rndSpeed, rndRun, rndUp);
    end

    applyStimulus(0, 0, 0, rndSpeed, 1, 1);
    @(negedge ClockIn);
    #1;
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
